// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and read-owner tags.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CORE  = 2'd1,
        ST_HOST  = 2'd2,
        ST_HLOCK = 2'd3
    } arbState_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } rdOwner_t;

    // Width of the host starvation counter; holds MAX_WAIT up to 15.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between core MEM stage, host port, arbiter and synchronous data RAM.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8
);
    // Handshake: a requester holds req (and its we/addr/wdata/func3) stable until it
    // sees gnt in the same cycle; dropping req without gnt is a no-op. A granted read
    // returns exactly one rvalid pulse with rdata on the following cycle.
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [2:0]        c_func3;
    logic              c_gnt;
    logic              c_rvalid;
    logic [31:0]       c_rdata;
    logic              core_stall;

    logic              h_req;
    logic              h_we;
    logic              h_lock;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata;
    logic [2:0]        h_func3;
    logic              h_gnt;
    logic              h_rvalid;
    logic [31:0]       h_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_wren;
    logic [2:0]        m_func3;
    logic [31:0]       m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_func3,
        output c_gnt, c_rvalid, c_rdata, core_stall,
        input  h_req, h_we, h_lock, h_addr, h_wdata, h_func3,
        output h_gnt, h_rvalid, h_rdata,
        output m_addr, m_wdata, m_wren, m_func3,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_func3,
        input  c_gnt, c_rvalid, c_rdata, core_stall,
        output h_req, h_we, h_lock, h_addr, h_wdata, h_func3,
        input  h_gnt, h_rvalid, h_rdata,
        input  m_addr, m_wdata, m_wren, m_func3,
        output m_rdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Host starvation counter: counts cycles the host waits ungranted, saturating at MAX_WAIT.
module arb_starve_cnt #(
    parameter int MAX_WAIT = 4,
    parameter int W        = 4
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         hReq,
    input  logic         hGnt,
    output logic [W-1:0] count,
    output logic         hit
);

    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (!hReq || hGnt) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + W'(1);
        end
    end

    assign hit = (count == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core MEM stage and host port onto one synchronous data RAM.
// Optional host anti-starvation is built only when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                clock,
    input  logic                clear,
    dmem_arbiter_if.slave       bus,
    output arbState_t           dbgState,
    output logic [STARVE_W-1:0] dbgStarveCnt
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_badMaxWait
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

    arbState_t           state;
    arbState_t           stateNext;
    rdOwner_t            rdOwner;
    rdOwner_t            rdOwnerNext;
    logic                cGnt;
    logic                hGnt;
    logic                starveHit;
    logic [STARVE_W-1:0] starveCnt;
    logic [ADDR_W-1:0]   mAddr;

`ifdef DMEM_ARB_STARVE_EN
    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .W        (STARVE_W)
    ) u_starve (
        .clock (clock),
        .clear (clear),
        .hReq  (bus.h_req),
        .hGnt  (hGnt),
        .count (starveCnt),
        .hit   (starveHit)
    );
`else
    assign starveHit = 1'b0;
    assign starveCnt = '0;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= ST_IDLE;
            rdOwner <= OWN_NONE;
        end else begin
            state   <= stateNext;
            rdOwner <= rdOwnerNext;
        end
    end

    // Grants are combinational so the RAM sees the winner's address this cycle.
    always_comb begin
        cGnt      = 1'b0;
        hGnt      = 1'b0;
        stateNext = state;
        if (!clear) begin
            case (state)
                ST_HLOCK: begin
                    hGnt      = bus.h_req;
                    stateNext = (bus.h_req && bus.h_lock) ? ST_HLOCK : ST_IDLE;
                end
                default: begin
                    if (starveHit && bus.h_req) begin
                        hGnt = 1'b1;
                    end else if (bus.c_req) begin
                        cGnt = 1'b1;
                    end else if (bus.h_req) begin
                        hGnt = 1'b1;
                    end
                    if (cGnt) begin
                        stateNext = ST_CORE;
                    end else if (hGnt) begin
                        stateNext = bus.h_lock ? ST_HLOCK : ST_HOST;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rdOwnerNext = OWN_NONE;
        if (cGnt && !bus.c_we) begin
            rdOwnerNext = OWN_CORE;
        end else if (hGnt && !bus.h_we) begin
            rdOwnerNext = OWN_HOST;
        end
    end

    assign mAddr       = hGnt ? bus.h_addr : bus.c_addr;
    assign bus.m_addr  = mAddr;
    assign bus.m_wdata = hGnt ? bus.h_wdata : bus.c_wdata;
    assign bus.m_func3 = hGnt ? bus.h_func3 : bus.c_func3;
    assign bus.m_wren  = (cGnt && bus.c_we) || (hGnt && bus.h_we);

    assign bus.c_gnt      = cGnt;
    assign bus.h_gnt      = hGnt;
    assign bus.core_stall = bus.c_req && !cGnt;

    // RAM data is only forwarded to the owner of last cycle's read; otherwise zero.
    assign bus.c_rvalid = (rdOwner == OWN_CORE);
    assign bus.h_rvalid = (rdOwner == OWN_HOST);
    assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : 32'h0;
    assign bus.h_rdata  = bus.h_rvalid ? bus.m_rdata : 32'h0;

    assign dbgState     = state;
    assign dbgStarveCnt = starveCnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a behavioural arbitration model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int ADDR_W   = 8;
    localparam int MAX_WAIT = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic                clock;
    logic                clear;
    arbState_t           dbgState;
    logic [STARVE_W-1:0] dbgStarveCnt;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .bus          (bus),
        .dbgState     (dbgState),
        .dbgStarveCnt (dbgStarveCnt)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous RAM: read data one cycle after address
    logic [31:0] ram [0:255];
    always @(posedge clock) begin
        if (bus.m_wren) ram[bus.m_addr] <= bus.m_wdata;
        bus.m_rdata <= ram[bus.m_addr];
    end

    // reference model state
    logic [31:0] modelMem [0:255];
    logic [31:0] exp_q[$];
    int          locked;
    int          waitCnt;
    int          lastKind;   // 0 none, 1 core, 2 host
    int          pendOwner;  // 0 none, 1 core, 2 host
    int          nChecks;
    int          nErrors;
    int          stallCount;
    int          hGntCount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic setCore(input logic req, input logic we, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3);
        bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd; bus.c_func3 = f3;
    endtask

    task automatic setHost(input logic req, input logic we, input logic lock, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3);
        bus.h_req = req; bus.h_we = we; bus.h_lock = lock; bus.h_addr = addr;
        bus.h_wdata = wd; bus.h_func3 = f3;
    endtask

    task automatic idleAll();
        setCore(1'b0, 1'b0, 8'h00, 32'h0, 3'd0);
        setHost(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 3'd0);
    endtask

    function automatic logic [31:0] preVal(input int a);
        if (a == 16'h10) return 32'hDEADBEEF;
        if (a == 1)      return 32'h11111111;
        if (a == 2)      return 32'h22222222;
        return 32'h5A000000 + 32'(a) * 32'h00010101;
    endfunction

    // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        logic        eC, eH, cWe, hWe, hReq, hLock, wasLocked;
        logic [7:0]  cAddr, hAddr;
        logic [31:0] cWd, hWd, eData;
        arbState_t   eState;
        #3;
        if (clear) begin
            locked = 0; waitCnt = 0; lastKind = 0; pendOwner = 0; exp_q.delete();
        end
        eC = 1'b0; eH = 1'b0;
        if (!clear) begin
            if (locked != 0)                                   eH = bus.h_req;
            else if (STARVE_EN && waitCnt >= MAX_WAIT && bus.h_req) eH = 1'b1;
            else if (bus.c_req)                                eC = 1'b1;
            else if (bus.h_req)                                eH = 1'b1;
        end
        chk("c_gnt", bus.c_gnt, eC);
        chk("h_gnt", bus.h_gnt, eH);
        chk("m_wren", bus.m_wren, (eC & bus.c_we) | (eH & bus.h_we));
        chk("m_addr", bus.m_addr, eH ? bus.h_addr : bus.c_addr);
        chk("m_wdata", bus.m_wdata, eH ? bus.h_wdata : bus.c_wdata);
        chk("m_func3", bus.m_func3, eH ? bus.h_func3 : bus.c_func3);
        chk("core_stall", bus.core_stall, bus.c_req & ~eC);
        chk("c_rvalid", bus.c_rvalid, pendOwner == 1);
        chk("h_rvalid", bus.h_rvalid, pendOwner == 2);
        eData = 32'h0;
        if (pendOwner != 0 && exp_q.size() > 0) eData = exp_q.pop_front();
        chk("c_rdata", bus.c_rdata, (pendOwner == 1) ? eData : 32'h0);
        chk("h_rdata", bus.h_rdata, (pendOwner == 2) ? eData : 32'h0);
        eState = (locked != 0) ? ST_HLOCK : (lastKind == 1) ? ST_CORE :
                 (lastKind == 2) ? ST_HOST : ST_IDLE;
        chk("state", dbgState, eState);
`ifdef DMEM_ARB_STARVE_EN
        chk("starve_cnt", dbgStarveCnt, waitCnt);
`endif
        if (bus.core_stall === 1'b1) stallCount++;
        if (bus.h_gnt === 1'b1) hGntCount++;
        cWe = bus.c_we; cAddr = bus.c_addr; cWd = bus.c_wdata;
        hWe = bus.h_we; hAddr = bus.h_addr; hWd = bus.h_wdata;
        hReq = bus.h_req; hLock = bus.h_lock;
        @(posedge clock);
        #1;
        if (!clear) begin
            pendOwner = 0;
            if (eC && !cWe) begin pendOwner = 1; exp_q.push_back(modelMem[cAddr]); end
            if (eH && !hWe) begin pendOwner = 2; exp_q.push_back(modelMem[hAddr]); end
            if (eC && cWe) modelMem[cAddr] = cWd;
            if (eH && hWe) modelMem[hAddr] = hWd;
            wasLocked = (locked != 0);
            locked    = (eH && hLock) ? 1 : 0;
            if (hReq && !eH) waitCnt = (waitCnt < MAX_WAIT) ? waitCnt + 1 : MAX_WAIT;
            else             waitCnt = 0;
            lastKind  = wasLocked ? 0 : eC ? 1 : eH ? 2 : 0;
        end
    endtask

    initial begin
        nChecks = 0; nErrors = 0; stallCount = 0; hGntCount = 0;
        locked = 0; waitCnt = 0; lastKind = 0; pendOwner = 0;
        idleAll();
        clear = 1'b1;
        @(posedge clock); #1;
        cycle();
        chk("reset_state", dbgState, ST_IDLE);
        clear = 1'b0;

        // preload through the host port
        for (int a = 0; a < 32; a++) begin
            setHost(1'b1, 1'b1, 1'b0, 8'(a), preVal(a), 3'd2);
            cycle();
        end
        idleAll();
        cycle();

        // core read of 0x10
        setCore(1'b1, 1'b0, 8'h10, 32'h0, 3'd2);
        cycle();
        idleAll();
        chk("read_c_rvalid", bus.c_rvalid, 1'b1);
        chk("read_c_rdata", bus.c_rdata, 32'hDEADBEEF);
        cycle();

        // write collision: core wins, host goes once core drops
        setCore(1'b1, 1'b1, 8'h05, 32'hC0C0C0C0, 3'd2);
        setHost(1'b1, 1'b1, 1'b0, 8'h06, 32'h0B0B0B0B, 3'd2);
        cycle();
        setCore(1'b0, 1'b0, 8'h00, 32'h0, 3'd0);
        cycle();
        idleAll();
        cycle();
        chk("collision_mem5", ram[8'h05], 32'hC0C0C0C0);
        chk("collision_mem6", ram[8'h06], 32'h0B0B0B0B);

        // locked host burst 0x20..0x23 while the core waits
        stallCount = 0; hGntCount = 0;
        setHost(1'b1, 1'b1, 1'b1, 8'h20, 32'hA0000020, 3'd2);
        cycle();
        setCore(1'b1, 1'b0, 8'h01, 32'h0, 3'd2);
        for (int i = 1; i < 4; i++) begin
            setHost(1'b1, 1'b1, 1'b1, 8'(32 + i), 32'hA0000020 + 32'(i), 3'd2);
            cycle();
        end
        setHost(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 3'd0);
        cycle();
        chk("lock_hgnt_count", hGntCount, 4);
        chk("lock_stall_count", stallCount, 4);
        cycle();
        idleAll();
        cycle();

        // starvation: both held for five cycles
        hGntCount = 0;
        setCore(1'b1, 1'b0, 8'h01, 32'h0, 3'd2);
        setHost(1'b1, 1'b0, 1'b0, 8'h02, 32'h0, 3'd2);
        for (int i = 0; i < 5; i++) cycle();
        chk("starve_hgnt", hGntCount, STARVE_EN ? 1 : 0);
        idleAll();
        cycle();
        cycle();

        // interleaved reads core 0x01 then host 0x02
        setCore(1'b1, 1'b0, 8'h01, 32'h0, 3'd2);
        cycle();
        setCore(1'b0, 1'b0, 8'h00, 32'h0, 3'd0);
        setHost(1'b1, 1'b0, 1'b0, 8'h02, 32'h0, 3'd2);
        cycle();
        idleAll();
        cycle();
        cycle();

        // reset pulsed the cycle after a core read grant
        setCore(1'b1, 1'b0, 8'h10, 32'h0, 3'd2);
        cycle();
        setCore(1'b1, 1'b1, 8'h10, 32'h12345678, 3'd2);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        setCore(1'b1, 1'b0, 8'h10, 32'h0, 3'd2);
        cycle();
        idleAll();
        cycle();

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            setCore($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)));
            setHost($urandom_range(0, 99) < 50, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) < 2, 8'($urandom_range(0, 31)), $urandom,
                    3'($urandom_range(0, 7)));
            clear = ($urandom_range(0, 99) == 0);
            cycle();
            clear = 1'b0;
        end
        idleAll();
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data-memory word address width.
REQ-002 SHALL have parameter MAX_WAIT, default 4, host-starvation limit in cycles (1..15).
REQ-003 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port clear  in  1  asynchronous active-high reset.
REQ-005 SHALL have core ports: c_req in 1, c_we in 1, c_addr in ADDR_W, c_wdata in 32, c_func3 in 3, c_gnt out 1, c_rvalid out 1, c_rdata out 32.
REQ-006 SHALL have host ports: h_req in 1, h_we in 1, h_lock in 1, h_addr in ADDR_W, h_wdata in 32, h_func3 in 3, h_gnt out 1, h_rvalid out 1, h_rdata out 32.
REQ-007 SHALL have memory ports: m_addr out ADDR_W, m_wdata out 32, m_wren out 1, m_func3 out 3, m_rdata in 32 (synchronous RAM, data valid one cycle after address).
REQ-008 SHALL have port core_stall  out  1  freezes core pipeline while a core request is not granted.

Function
REQ-009 SHALL grant at most one requester per cycle; c_gnt and h_gnt never both 1.
REQ-010 SHALL drive m_addr/m_wdata/m_func3 combinationally from the granted requester; m_wren = granted requester's we; with no grant m_wren=0 and m_addr/m_wdata/m_func3 = core inputs.
REQ-011 SHALL implement FSM states IDLE, CORE, HOST, HLOCK, evaluated each cycle from the current state and requests.
REQ-012 SHALL in IDLE/CORE grant core when c_req=1, else host when h_req=1 (fixed core priority), subject to REQ-016.
REQ-013 SHALL enter HLOCK when host is granted with h_lock=1; in HLOCK grant host every cycle h_req=1 regardless of c_req; leave to IDLE when h_lock=0 or h_req=0.
REQ-014 SHALL assert core_stall = c_req & ~c_gnt, same cycle.
REQ-015 SHALL register a read-owner tag for every granted access with we=0; next cycle assert that owner's rvalid for exactly one cycle with its rdata = m_rdata; writes produce no rvalid.
REQ-016 (starvation) SHALL count cycles with h_req=1 & ~h_gnt; when count = MAX_WAIT, grant host next eligible cycle over c_req; counter clears on h_gnt or h_req=0, saturates at MAX_WAIT.
REQ-017 SHALL leave c_rdata/h_rdata at 0 when the matching rvalid=0.
REQ-018 SHALL deliver back-to-back reads from alternating requesters with one rvalid per cycle, each tagged to the correct owner.
REQ-019 SHALL treat request deassertion with no grant as a no-op (no memory access, no rvalid).

Reset
REQ-020 SHALL on clear=1, asynchronously: state=IDLE, starvation counter=0, read-owner tag=none, c_rvalid=h_rvalid=0, rdata outputs=0.
REQ-021 SHALL, when clear asserts mid-read or mid-HLOCK, drop the pending rvalid and the lock; first post-reset grant follows REQ-012.
REQ-022 SHALL hold all grants and m_wren at 0 while clear=1.

Configuration
REQ-023 SHALL compile REQ-016 only when macro DMEM_ARB_STARVE_EN is defined; without it, no counter exists and outside HLOCK the core always wins.

Structure
REQ-024 SHALL place FSM state encoding (2-bit IDLE/CORE/HOST/HLOCK) and read-owner tag encoding (NONE/CORE/HOST) in shared package dmem_arb_pkg.
REQ-025 SHALL be a single module; starvation counter may be sub-module arb_starve_cnt, instantiated only under DMEM_ARB_STARVE_EN.
REQ-026 SHALL sit between the core's MEM stage and the data RAM, replacing the direct MEM_aluResult/MEM_dataB/MemWrite connection.

Verification
REQ-027 Core read only: c_req=1,c_we=0,c_addr=0x10, RAM[0x10]=0xDEADBEEF -> c_gnt=1, core_stall=0, next cycle c_rvalid=1, c_rdata=0xDEADBEEF.
REQ-028 Collision: c_req=h_req=1 same cycle, both writes -> c_gnt=1,h_gnt=0,m_wren=1,m_wdata=c_wdata; host granted first cycle c_req=0.
REQ-029 Lock: host h_lock=1 writes 0x20..0x23 while c_req=1 -> 4 consecutive h_gnt, core_stall=1 for 4 cycles, c_gnt on cycle after h_lock=0.
REQ-030 Starvation (DMEM_ARB_STARVE_EN, MAX_WAIT=4): c_req held 1, h_req held 1 -> h_gnt=1 on 5th cycle, core_stall=1 that cycle, counter back to 0; without macro h_gnt stays 0.
REQ-031 Interleaved reads: core read 0x01 then host read 0x02 on next cycle -> c_rvalid then h_rvalid on consecutive cycles with correct data, never both.
REQ-032 Reset mid-read: clear pulsed the cycle after core read grant -> c_rvalid stays 0, state IDLE, m_wren=0 during clear.
